fifo_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It pops a commanded number of words through the FIFO's `rden`/`empty` handshake and accounts for the FIFO's one-cycle registered read latency. It re-presents the words on a valid/ready stream with a last-beat marker. It sits between a FIFO and a downstream consumer such as a MAC or result collector, and sustains one word per cycle when the consumer is always ready.

---
 rtl/fifo_reader_pkg.sv | 21 ++
 rtl/fifo_reader_skid.sv | 62 ++++++
 rtl/fifo_reader.sv | 119 +++++++++++
 tb/tb_fifo_reader.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// ============================================================================
//  Module   : fifo_reader_pkg
//  Purpose  : Shared types and constants for the FIFO read-side controller.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fifo_reader_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_reader_skid.sv
// ============================================================================
//  Module   : fifo_reader_skid
//  Purpose  : Two-entry skid buffer absorbing the FIFO's registered read data.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] r_ent0;
  logic [DATA_WIDTH-1:0] r_ent1;
  logic [1:0]            r_occ;

  // Entry 0 is always the head; entry 1 only holds data when two words wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (r_occ == 2'd0) r_ent0 <= din;
          else               r_ent1 <= din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'(SKID_DEPTH)) begin
            r_ent0 <= r_ent1;
            r_ent1 <= din;
          end else begin
            r_ent0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = r_occ;
  assign head = r_ent0;

endmodule

`default_nettype wire

// File: rtl/fifo_reader.sv
// ============================================================================
//  Module   : fifo_reader
//  Purpose  : Pops a commanded burst from a synchronous FIFO onto a
//             valid/ready stream with a last-beat marker.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rden,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_issue_cnt;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [1:0]           w_occ;
  logic                 w_pop;
  logic [2:0]           w_credit;

  assign m_valid = (w_occ != 2'd0);
  assign w_pop   = m_valid && m_ready;
  assign m_last  = m_valid && (r_beat_cnt == CNT_WIDTH'(1));

  // Words already buffered or in flight, minus the one leaving this cycle,
  // must leave room for the word a new read would deliver.
  assign w_credit  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rden = (r_state == RUN) && !fifo_empty &&
                     (r_issue_cnt != '0) && (w_credit < 3'(SKID_DEPTH));

  assign busy = (r_state != IDLE);
  assign done = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (len != '0) w_state_nxt = RUN;
          else           w_done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (fifo_rden && (r_issue_cnt == CNT_WIDTH'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_pop && (r_beat_cnt == CNT_WIDTH'(1))) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= fifo_rden;
      if ((r_state == IDLE) && start && (len != '0)) begin
        r_issue_cnt <= len;
        r_beat_cnt  <= len;
      end else begin
        if (fifo_rden && (r_issue_cnt != '0)) r_issue_cnt <= r_issue_cnt - CNT_WIDTH'(1);
        if (w_pop && (r_beat_cnt != '0))      r_beat_cnt  <= r_beat_cnt - CNT_WIDTH'(1);
      end
    end
  end

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   (fifo_rdata),
    .occ   (w_occ),
    .head  (m_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_reader.sv
// ============================================================================
//  Module   : tb_fifo_reader
//  Purpose  : Self-checking bench for fifo_reader with a queue-based FIFO and
//             expected-word model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len   = '0;
  logic          busy, done, fifo_rden, fifo_empty, m_valid, m_last, m_ready;
  logic [DW-1:0] m_data;
  logic [DW-1:0] fifo_rdata = '0;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .fifo_rden  (fifo_rden),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  // FIFO model with one-cycle registered read latency; it is not reset.
  logic [DW-1:0] fifo_mem [256];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_rdata <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
    end
  end

  // Words in the order the consumer should see them.
  logic [DW-1:0] exp_q [$];

  // Consumer ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  int rdy_mode = 0;
  initial begin
    int idx;
    idx = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          m_ready = (idx == 0) || (idx == 3);
          idx = (idx + 1) % 4;
        end
        2:       m_ready = ($urandom_range(0, 2) != 0);
        default: m_ready = 1'b1;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] beat_q [$];
  logic          last_q [$];
  int            beat_cyc_q [$];
  int            done_cyc_q [$];
  int            rden_cnt = 0, rden_bad = 0, hold_bad = 0, valid_cnt = 0, max_occ = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        hold_bad++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        beat_q.push_back(m_data);
        last_q.push_back(m_last);
        beat_cyc_q.push_back(cyc);
      end
      if (fifo_rden) rden_cnt++;
      if (fifo_rden && fifo_empty) rden_bad++;
      if (done) done_cyc_q.push_back(cyc);
      if (int'(dut.u_skid.occ) > max_occ) max_occ = int'(dut.u_skid.occ);
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  // c is the cycle number just before the edge that samples start.
  task automatic issue(input int l, output int c);
    @(posedge clk); #1;
    start = 1'b1;
    len   = CW'(l);
    c     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cyc_q.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, fifo_rden, m_valid, m_last, m_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b rden=%b valid=%b last=%b data=%h, want all 0",
               busy, done, fifo_rden, m_valid, m_last, m_data);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, fifo_rden, m_valid} !== 4'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b done=%b rden=%b valid=%b, want 0", busy, done, fifo_rden, m_valid);
    end
  endtask

  task automatic test_basic();
    int c, b0, r0, d0;
    bit ok;
    logic [DW-1:0] e, g;
    for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
    b0 = beat_q.size(); r0 = rden_cnt; d0 = done_cyc_q.size();
    issue(8, c);
    wait_done(d0, 40, ok);
    repeat (3) @(posedge clk);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL basic_done_timeout: no done within 40 cycles"); end
    tests_run++;
    if (rden_cnt - r0 != 8) begin fails++; $display("FAIL basic_rden_cycles: got %0d, want 8", rden_cnt - r0); end
    tests_run++;
    if (done_cyc_q.size() - d0 != 1) begin fails++; $display("FAIL basic_done_count: got %0d, want 1", done_cyc_q.size() - d0); end
    else begin
      tests_run++;
      if (done_cyc_q[d0] != c + 1 + 10) begin
        fails++; $display("FAIL basic_done_cycle: got E0+%0d, want E0+10", done_cyc_q[d0] - c - 1);
      end
    end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      g = (b0 + k < beat_q.size()) ? beat_q[b0 + k] : 'x;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL basic_beat%0d: got %h, want %h", k, g, e); end
      else begin
        tests_run++;
        if (beat_cyc_q[b0 + k] != c + 3 + k || last_q[b0 + k] !== (k == 7)) begin
          fails++;
          $display("FAIL basic_beat%0d_timing: cycle E0+%0d last=%b, want E0+%0d last=%b",
                   k, beat_cyc_q[b0 + k] - c - 1, last_q[b0 + k], k + 2, (k == 7));
        end
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b, want 0", busy); end
  endtask

  task automatic test_backpressure();
    int c, b0, r0, d0, h0;
    bit ok;
    logic [DW-1:0] e, g;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    b0 = beat_q.size(); r0 = rden_cnt; d0 = done_cyc_q.size(); h0 = hold_bad;
    rdy_mode = 1;
    issue(4, c);
    wait_done(d0, 60, ok);
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    tests_run++;
    if (!ok || done_cyc_q.size() - d0 != 1) begin
      fails++; $display("FAIL bp_done: got %0d pulses, want 1", done_cyc_q.size() - d0);
    end
    tests_run++;
    if (beat_q.size() - b0 != 4 || rden_cnt - r0 != 4) begin
      fails++; $display("FAIL bp_counts: got beats=%0d reads=%0d, want 4 and 4", beat_q.size() - b0, rden_cnt - r0);
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      g = (b0 + k < beat_q.size()) ? beat_q[b0 + k] : 'x;
      tests_run++;
      if (g !== e || (b0 + k < beat_q.size() && last_q[b0 + k] !== (k == 3))) begin
        fails++; $display("FAIL bp_beat%0d: got %h, want %h (last on final only)", k, g, e);
      end
    end
    tests_run++;
    if (hold_bad != h0) begin fails++; $display("FAIL bp_hold_stable: got %0d unstable stalls, want 0", hold_bad - h0); end
    tests_run++;
    if (max_occ > 2) begin fails++; $display("FAIL bp_occ: got max %0d, want <= 2", max_occ); end
  endtask

  task automatic test_starvation();
    int c, b0, r0, d0, x0;
    bit ok;
    logic [DW-1:0] e, g;
    logic [DW-1:0] words [3];
    for (int i = 0; i < 3; i++) words[i] = DW'($urandom);
    b0 = beat_q.size(); r0 = rden_cnt; d0 = done_cyc_q.size(); x0 = rden_bad;
    issue(3, c);
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(posedge clk);
      #1 push_word(words[i]);
    end
    wait_done(d0, 40, ok);
    repeat (3) @(posedge clk);
    tests_run++;
    if (!ok || done_cyc_q.size() - d0 != 1) begin
      fails++; $display("FAIL starve_done: got %0d pulses, want 1", done_cyc_q.size() - d0);
    end
    tests_run++;
    if (rden_bad != x0 || rden_cnt - r0 != 3) begin
      fails++; $display("FAIL starve_reads: got %0d reads (%0d while empty), want 3 (0)", rden_cnt - r0, rden_bad - x0);
    end
    tests_run++;
    if (beat_q.size() - b0 != 3) begin fails++; $display("FAIL starve_beats: got %0d, want 3", beat_q.size() - b0); end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      g = (b0 + k < beat_q.size()) ? beat_q[b0 + k] : 'x;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL starve_beat%0d: got %h, want %h", k, g, e); end
    end
  endtask

  task automatic test_zero_and_restart();
    int c, b0, r0, d0, v0;
    bit ok;
    logic [DW-1:0] e, g;
    r0 = rden_cnt; d0 = done_cyc_q.size(); v0 = valid_cnt;
    issue(0, c);
    repeat (4) @(posedge clk);
    tests_run++;
    if (done_cyc_q.size() - d0 != 1) begin
      fails++; $display("FAIL zero_done_count: got %0d, want 1", done_cyc_q.size() - d0);
    end else begin
      tests_run++;
      if (done_cyc_q[d0] != c + 1) begin
        fails++; $display("FAIL zero_done_cycle: got E0+%0d, want E0+0", done_cyc_q[d0] - c - 1);
      end
    end
    tests_run++;
    if (rden_cnt != r0 || valid_cnt != v0) begin
      fails++; $display("FAIL zero_activity: got reads=%0d valids=%0d, want 0 and 0", rden_cnt - r0, valid_cnt - v0);
    end
    // A second start while busy must not reload the count.
    for (int i = 0; i < 12; i++) push_word(DW'($urandom));
    b0 = beat_q.size(); r0 = rden_cnt; d0 = done_cyc_q.size();
    issue(4, c);
    @(posedge clk); #1;
    start = 1'b1; len = CW'(9);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 40, ok);
    repeat (4) @(posedge clk);
    tests_run++;
    if (!ok || done_cyc_q.size() - d0 != 1 || beat_q.size() - b0 != 4 || rden_cnt - r0 != 4) begin
      fails++;
      $display("FAIL restart_ignored: got done=%0d beats=%0d reads=%0d, want 1, 4, 4",
               done_cyc_q.size() - d0, beat_q.size() - b0, rden_cnt - r0);
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      g = (b0 + k < beat_q.size()) ? beat_q[b0 + k] : 'x;
      tests_run++;
      if (g !== e || (b0 + k < beat_q.size() && last_q[b0 + k] !== (k == 3))) begin
        fails++; $display("FAIL restart_beat%0d: got %h, want %h (last on final only)", k, g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, b0, d0, guard;
    bit ok;
    logic [DW-1:0] e, g;
    // The restart test leaves 8 words queued; add one so the burst never starves.
    push_word(DW'($urandom));
    b0 = beat_q.size();
    issue(6, c);
    guard = 0;
    while (cyc < c + 6 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    // Reads were accepted at E1..E5, three beats delivered at E3..E5.
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, fifo_rden, m_valid, m_last, m_data} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got busy=%b done=%b rden=%b valid=%b last=%b data=%h, want all 0",
               busy, done, fifo_rden, m_valid, m_last, m_data);
    end
    tests_run++;
    if (beat_q.size() - b0 != 3) begin fails++; $display("FAIL midreset_beats: got %0d, want 3", beat_q.size() - b0); end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      g = (b0 + k < beat_q.size()) ? beat_q[b0 + k] : 'x;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL midreset_beat%0d: got %h, want %h", k, g, e); end
    end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b0 = beat_q.size(); d0 = done_cyc_q.size();
    issue(2, c);
    wait_done(d0, 30, ok);
    repeat (2) @(posedge clk);
    tests_run++;
    if (!ok || beat_q.size() - b0 != 2) begin
      fails++; $display("FAIL postreset_burst: got %0d beats, want 2", beat_q.size() - b0);
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      g = (b0 + k < beat_q.size()) ? beat_q[b0 + k] : 'x;
      tests_run++;
      if (g !== e || (b0 + k < beat_q.size() && last_q[b0 + k] !== (k == 1))) begin
        fails++; $display("FAIL postreset_beat%0d: got %h, want %h (last on final only)", k, g, e);
      end
    end
  endtask

  task automatic test_random();
    int c, b0, r0, d0, l;
    bit ok;
    logic [DW-1:0] e, g;
    rdy_mode = 2;
    for (int it = 0; it < 6; it++) begin
      l = $urandom_range(1, 12);
      for (int i = 0; i < exp_q.size(); i++) ;
      for (int i = 0; i < l; i++) push_word(DW'($urandom));
      b0 = beat_q.size(); r0 = rden_cnt; d0 = done_cyc_q.size();
      issue(l, c);
      wait_done(d0, 200, ok);
      repeat (2) @(posedge clk);
      tests_run++;
      if (!ok || done_cyc_q.size() - d0 != 1 || rden_cnt - r0 != l || beat_q.size() - b0 != l) begin
        fails++;
        $display("FAIL rand%0d_counts: got done=%0d reads=%0d beats=%0d, want 1, %0d, %0d",
                 it, done_cyc_q.size() - d0, rden_cnt - r0, beat_q.size() - b0, l, l);
      end
      for (int k = 0; k < l; k++) begin
        e = exp_q.pop_front();
        g = (b0 + k < beat_q.size()) ? beat_q[b0 + k] : 'x;
        tests_run++;
        if (g !== e || (b0 + k < beat_q.size() && last_q[b0 + k] !== (k == l - 1))) begin
          fails++; $display("FAIL rand%0d_beat%0d: got %h, want %h (last on final only)", it, k, g, e);
        end
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_zero_and_restart();
    test_reset_mid();
    test_random();
    tests_run++;
    if (rden_bad != 0 || hold_bad != 0 || max_occ > 2) begin
      fails++;
      $display("FAIL global_invariants: got rden_while_empty=%0d unstable_stalls=%0d max_occ=%0d, want 0, 0, <=2",
               rden_bad, hold_bad, max_occ);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
